calc_arith_unit: RTL
====================

Name: calc_arith_unit

Overview:
- Sequential arithmetic engine for the simple calculator. Sits between the operand/operator entry FSM and the VGA/SSD output stages.
- Accepts two latched 16-bit operands and an opcode on a one-cycle Start pulse. Computes add/sub in one step and mul/div iteratively (one bit per clock).
- Returns a 17-bit result, a remainder, an error/sign flag and a one-cycle Done pulse.

Parameters:
- WIDTH, 16, operand width; C is WIDTH+1 bits, Rem is WIDTH bits, iteration count = WIDTH.

Ports:
- Clk  in  1  system clock (board_clk, 100 MHz)
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle request pulse, e.g. debounced SCEN
- Op  in  2  00 add, 01 sub, 10 mul, 11 div
- A  in  WIDTH  first operand
- B  in  WIDTH  second operand
- C  out  WIDTH+1  result
- Rem  out  WIDTH  division remainder; 0 for other ops
- Flag  out  1  sub: result negative; mul: overflow; div: divide-by-zero
- Busy  out  1  high while computing
- Done  out  1  one-cycle completion pulse

Behaviour:
- One clock; reset is synchronous and active-high, on Clk and Reset.
- Reset values: state=IDLE, C=0, Rem=0, Flag=0, Busy=0, Done=0, iteration counter=0, internal operand and accumulator registers=0.
- States: IDLE, ADDSUB, MUL, DIV, DONE.
  - Busy = (state is ADDSUB, MUL or DIV).
  - Done = (state==DONE).
- Accept rule: Start sampled high at a rising edge while in IDLE (edge k):
  - Latch A, B, Op into internal registers.
  - Clear counter.
  - Go to ADDSUB (Op 00/01), MUL (10) or DIV (11).
- Start in any other state is ignored, with no queuing. A, B and Op changes after edge k have no effect.
- ADDSUB (edge k+1), then go to DONE:
  - Add: C = A+B, 17-bit with carry in C[16]; Flag=0.
  - Sub: if A>=B then C = A−B, Flag=0; else C = B−A (magnitude), Flag=1.
  - Rem=0.
- MUL: shift-add, one multiplier bit per edge, 32-bit accumulator; edges k+1..k+16.
  - At edge k+16: C = product[16:0]; Flag=1 iff product[31:17]≠0; Rem=0; go to DONE.
- DIV:
  - If latched B==0 at edge k+1: C=0, Rem=0, Flag=1; go to DONE.
  - Otherwise restoring division, one quotient bit per edge, edges k+1..k+16.
  - At edge k+16: C={1'b0,quotient}, Rem=remainder, Flag=0; go to DONE.
- DONE: Done=1 for exactly one cycle; next edge go to IDLE unconditionally.
- Latency from accepting edge k to Done asserted:
  - Done asserted after edge k+1 for add, sub and div-by-zero.
  - Done asserted after edge k+16 for mul and div.
- Output registers C/Rem/Flag update only at the completing edge. They hold the previous result throughout a computation and until the next completion.
- Reset has priority over everything. Reset mid-operation returns to IDLE with all outputs at reset values; no Done is produced for the aborted operation.
- Start coincident with Reset is ignored.
- Counter: 5 bits, 0..WIDTH−1; no wrap beyond WIDTH.

Test Plan:
- Add with carry: Reset 2 cycles, then Start, Op=00, A=FFFF, B=FFFF -> C=1FFFE, Flag=0, Rem=0. Done high exactly one cycle, after edge k+1; Busy high one cycle.
- Subtraction:
  - Op=01, A=0003, B=0005 -> C=00002, Flag=1.
  - Then A=0005, B=0003 -> C=00002, Flag=0.
- Multiply:
  - Op=10, A=00FF, B=0101 -> C=0FFFF, Flag=0. Done after edge k+16; Busy high 16 cycles; C holds old value until completion.
  - Then A=1000, B=0020 -> C=00000, Flag=1 (overflow).
- Divide:
  - Op=11, A=1234, B=0010 -> C=00123, Rem=0004, Flag=0, Done after edge k+16.
  - Then B=0000 -> C=0, Rem=0, Flag=1, Done after edge k+1.
- Ignored Start and changing inputs: while a mul is busy, pulse Start with Op=00 and change A/B -> exactly one Done, with the original product. Start asserted during the DONE cycle is also ignored.
- Reset abort: assert Reset at edge k+5 of a divide -> next cycle Busy=0, Done=0, C=0, Flag=0, Rem=0, state IDLE. A fresh add then completes normally.

Source files
------------

// File: rtl/calc_arith_unit.sv
// rtl/calc_arith_unit.sv - sequential add/sub/mul/div engine for the calculator datapath
module calc_arith_unit #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   C,
  output logic [WIDTH-1:0] Rem,
  output logic             Flag,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDSUB,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

  state_t             state;
  logic               sub_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [4:0]         cnt;

  // shift-add multiplier: multiplicand walks left, multiplier walks right
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;

  // restoring divider: dividend bits shift out of dquot, quotient bits shift in
  logic [WIDTH-1:0]   dquot;
  logic [WIDTH-1:0]   drem;

  logic [WIDTH:0]     add_sum;
  logic               sub_ge;
  logic [WIDTH-1:0]   sub_mag;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   drem_next;
  logic [WIDTH-1:0]   dquot_next;

  // next-step arithmetic for every operation, selected by the FSM below
  always_comb begin
    add_sum   = {1'b0, a_r} + {1'b0, b_r};
    sub_ge    = (a_r >= b_r);
    sub_mag   = sub_ge ? (a_r - b_r) : (b_r - a_r);
    prod_next = prod + (mplier[0] ? mcand : '0);
    div_shift = {drem, dquot[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_r});
    // when the trial subtract succeeds the difference is below b_r, so the low WIDTH bits are exact
    drem_next  = div_ge ? (div_shift[WIDTH-1:0] - b_r) : div_shift[WIDTH-1:0];
    dquot_next = {dquot[WIDTH-2:0], div_ge};
  end

  // control FSM with registered result, status and handshake outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= S_IDLE;
      sub_r  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      dquot  <= '0;
      drem   <= '0;
      C      <= '0;
      Rem    <= '0;
      Flag   <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            sub_r  <= Op[0];
            a_r    <= A;
            b_r    <= B;
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            prod   <= '0;
            dquot  <= A;
            drem   <= '0;
            Busy   <= 1'b1;
            case (Op)
              2'b10:   state <= S_MUL;
              2'b11:   state <= S_DIV;
              default: state <= S_ADDSUB;
            endcase
          end
        end

        S_ADDSUB: begin
          if (sub_r) begin
            C    <= {1'b0, sub_mag};
            Flag <= ~sub_ge;
          end else begin
            C    <= add_sum;
            Flag <= 1'b0;
          end
          Rem   <= '0;
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= S_DONE;
        end

        S_MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          if (cnt == LAST_STEP) begin
            C     <= prod_next[WIDTH:0];
            Flag  <= |prod_next[2*WIDTH-1:WIDTH+1];
            Rem   <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        S_DIV: begin
          // a zero divisor is caught on the first step and finishes immediately
          if (cnt == 5'd0 && b_r == '0) begin
            C     <= '0;
            Rem   <= '0;
            Flag  <= 1'b1;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= S_DONE;
          end else begin
            drem  <= drem_next;
            dquot <= dquot_next;
            if (cnt == LAST_STEP) begin
              C     <= {1'b0, dquot_next};
              Rem   <= drem_next;
              Flag  <= 1'b0;
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= S_DONE;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end

        S_DONE: begin
          Done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
